tone_player: RTL and testbench
==============================

# tone_player

Programmable buzzer tone engine: plays one note per command at a runtime-selected frequency for a runtime-selected duration, then inserts a fixed silent articulation gap. It generalises the fixed-divider square-wave buzzer drive with several additions:
- per-note half-period and duration
- rests
- a valid/ready command handshake
- abort
- done signalling

It sits between a melody sequencer or control FSM and the board buzzer/LED pins.

## Interface
- TICK_CYC, 50000 — clk cycles per duration tick (1 ms at 50 MHz); ≥1
- DIV_W, 20 — width of half-period field (max half-period 2^DIV_W−1 clks)
- DUR_W, 12 — width of duration field, in ticks
- GAP_TICKS, 20 — silent gap after every note, in ticks; 0 = no gap
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_half_period  in  DIV_W  buzzer toggle interval in clks; 0 = rest (silent)
- cmd_duration  in  DUR_W  note length in ticks
- stop  in  1  synchronous abort of current note/gap
- bz  out  1  buzzer square wave
- led  out  1  high while PLAY with non-zero half-period (note-active indicator)
- busy  out  1  high in PLAY or GAP
- done  out  1  one-cycle pulse when a note (incl. gap) completes or is aborted

## Operation
- States: IDLE, PLAY, GAP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at an edge, latch half_period and duration, clear the tone counter and tick prescaler, and set bz=0.
  - Next state is PLAY if duration≠0; otherwise GAP, or IDLE when GAP_TICKS=0.
- PLAY (half_period≠0):
  - The tone counter increments every clk.
  - When it equals half_period−1: bz toggles and the counter clears.
  - Output frequency = clk/(2·half_period).
  - half_period=1 toggles bz every clk.
- PLAY (half_period=0): bz held 0, led=0; duration still counts.
- Tick prescaler:
  - Counts 0..TICK_CYC−1 in PLAY and GAP and emits a tick on wrap.
  - The remaining-duration counter decrements on each tick.
  - When remaining=1 and a tick occurs: go to GAP (or IDLE if GAP_TICKS=0), bz forced 0, prescaler cleared.
- GAP: bz=0, led=0. Lasts GAP_TICKS ticks, then IDLE.
- done: asserted for one cycle on every transition into IDLE from PLAY or GAP, including abort.
- stop:
  - In PLAY/GAP: the next state is IDLE, bz=0, done pulses.
  - In IDLE: ignored.
  - stop takes priority over tick and tone events in the same cycle.
  - A command presented in the same cycle as stop while in IDLE is accepted normally.
- Commands presented while busy are not accepted; cmd_valid may stay high and is taken in the first IDLE cycle (the same cycle done is high).
- Latched parameters are immune to input changes during PLAY/GAP.
- Counters never overflow: tone counter DIV_W bits, prescaler ⌈log2 TICK_CYC⌉ bits, duration DUR_W bits, gap counter sized for GAP_TICKS.

## Timing
- Reset values: bz=0, led=0, busy=0, done=0, cmd_ready=1, state IDLE, all counters 0.
- Accept at edge N: busy=1 from cycle N+1; first bz rising edge at edge N+half_period.
- PLAY lasts exactly duration·TICK_CYC cycles; GAP exactly GAP_TICKS·TICK_CYC cycles.
- done and cmd_ready both high in the first IDLE cycle.
  - Back-to-back commands therefore have 1 idle cycle between notes.
- All outputs are registered; no combinational path from inputs to bz/led/busy/done.
- cmd_ready is decoded from the state register.
- Reset asserted mid-note: outputs return to reset values immediately (asynchronous); no done pulse.

## Test plan
All scenarios use TICK_CYC=10, GAP_TICKS=2, DIV_W=8, DUR_W=4.
- Basic note: half_period=5, duration=3 → bz toggles every 5 clks, 6 toggles over 30 PLAY cycles, then 20 GAP cycles with bz=0; done=1 in cycle 51 after accept; busy high cycles 1–50.
- Rest: half_period=0, duration=2 → bz=0 and led=0 throughout, busy high 40 cycles, done pulse in cycle 41.
- Zero duration: duration=0 → no PLAY; 20 GAP cycles, done in cycle 21. With GAP_TICKS=0 rebuild, done in cycle 1.
- Abort: half_period=3, duration=5, stop in cycle 12 → IDLE next cycle, bz=0, single done pulse; a new command is accepted the following cycle.
- Back-to-back: cmd_valid held with two commands (hp=2 dur=1, hp=4 dur=1) → second accepted exactly in the done cycle of the first; busy low for 1 cycle only.
- Async reset mid-PLAY (hp=1, bz high) → bz, busy, led drop without waiting for clk; no done; cmd_ready=1 after release.

Source files
------------

// File: rtl/tone_player_if.sv
// Command channel of the tone engine: one note request (half-period, duration)
// moved with a valid/ready handshake from the melody sequencer to the player.
interface tone_player_if #(
    parameter int DIV_W = 20,
    parameter int DUR_W = 12
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [DIV_W-1:0] cmd_half_period;
    logic [DUR_W-1:0] cmd_duration;

    modport master (
        output cmd_valid,
        output cmd_half_period,
        output cmd_duration,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_half_period,
        input  cmd_duration,
        output cmd_ready
    );

endinterface : tone_player_if

// File: rtl/tone_player.sv
// Programmable buzzer tone engine: plays one square-wave note (or rest) per
// command for a number of ticks, then a fixed silent gap; abortable via stop.
module tone_player #(
    parameter int TICK_CYC  = 50000,
    parameter int DIV_W     = 20,
    parameter int DUR_W     = 12,
    parameter int GAP_TICKS = 20
) (
    input  logic         clk,
    input  logic         rst,
    tone_player_if.slave cmd,
    input  logic         stop,
    output logic         bz,
    output logic         led,
    output logic         busy,
    output logic         done
);

    localparam int PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);
    localparam bit               HAS_GAP  = (GAP_TICKS != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e           state_q;
    logic [DIV_W-1:0] hp_q;
    logic [DIV_W-1:0] tone_q;
    logic [PRE_W-1:0] presc_q;
    logic [DUR_W-1:0] dur_q;
    logic [GAP_W-1:0] gap_q;
    logic             bz_q;
    logic             led_q;
    logic             busy_q;
    logic             done_q;

    logic tick;
    logic tone_wrap;

    assign tick      = (presc_q == PRE_LAST);
    assign tone_wrap = (tone_q == hp_q - DIV_W'(1));

    // NOTE: all state uses non-blocking assignments; where a register is
    // assigned twice in one branch (tone toggle, then end-of-note clear),
    // the later assignment deliberately wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hp_q    <= '0;
            tone_q  <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
            bz_q    <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (stop && state_q != S_IDLE) begin
                // Abort outranks any tick or tone event in the same cycle.
                state_q <= S_IDLE;
                tone_q  <= '0;
                presc_q <= '0;
                bz_q    <= 1'b0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (cmd.cmd_valid) begin
                            hp_q    <= cmd.cmd_half_period;
                            tone_q  <= '0;
                            presc_q <= '0;
                            bz_q    <= 1'b0;
                            if (cmd.cmd_duration != '0) begin
                                state_q <= S_PLAY;
                                dur_q   <= cmd.cmd_duration;
                                led_q   <= (cmd.cmd_half_period != '0);
                                busy_q  <= 1'b1;
                            end else if (HAS_GAP) begin
                                state_q <= S_GAP;
                                gap_q   <= GAP_INIT;
                                busy_q  <= 1'b1;
                            end else begin
                                done_q  <= 1'b1;
                            end
                        end
                    end

                    S_PLAY: begin
                        presc_q <= tick ? '0 : presc_q + PRE_W'(1);

                        if (hp_q != '0) begin
                            if (tone_wrap) begin
                                bz_q   <= ~bz_q;
                                tone_q <= '0;
                            end else begin
                                tone_q <= tone_q + DIV_W'(1);
                            end
                        end

                        if (tick) begin
                            dur_q <= dur_q - DUR_W'(1);
                            if (dur_q == DUR_W'(1)) begin
                                bz_q   <= 1'b0;
                                led_q  <= 1'b0;
                                tone_q <= '0;
                                if (HAS_GAP) begin
                                    state_q <= S_GAP;
                                    gap_q   <= GAP_INIT;
                                end else begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end
                        end
                    end

                    S_GAP: begin
                        presc_q <= tick ? '0 : presc_q + PRE_W'(1);
                        if (tick) begin
                            gap_q <= gap_q - GAP_W'(1);
                            if (gap_q == GAP_W'(1)) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        bz_q    <= 1'b0;
                        led_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign bz            = bz_q;
    assign led           = led_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule : tone_player

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: directed vector table, hand-written
// corner sequences, and randomized notes against a timing-rule reference model.
module tb_tone_player;

    localparam int TICK_CYC  = 10;
    localparam int GAP_TICKS = 2;
    localparam int DIV_W     = 8;
    localparam int DUR_W     = 4;
    localparam int BUDGET    = 300;

    logic clk = 1'b0;
    logic rst;
    logic stop, bz, led, busy, done;
    logic stop_ng, bz_ng, led_ng, busy_ng, done_ng;

    int n_checks = 0;
    int n_pass   = 0;

    tone_player_if #(.DIV_W(DIV_W), .DUR_W(DUR_W)) cmd_if ();
    tone_player_if #(.DIV_W(DIV_W), .DUR_W(DUR_W)) cmd_ng_if ();

    tone_player #(
        .TICK_CYC (TICK_CYC),
        .DIV_W    (DIV_W),
        .DUR_W    (DUR_W),
        .GAP_TICKS(GAP_TICKS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .cmd (cmd_if),
        .stop(stop),
        .bz  (bz),
        .led (led),
        .busy(busy),
        .done(done)
    );

    tone_player #(
        .TICK_CYC (TICK_CYC),
        .DIV_W    (DIV_W),
        .DUR_W    (DUR_W),
        .GAP_TICKS(0)
    ) u_dut_ng (
        .clk (clk),
        .rst (rst),
        .cmd (cmd_ng_if),
        .stop(stop_ng),
        .bz  (bz_ng),
        .led (led_ng),
        .busy(busy_ng),
        .done(done_ng)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hp;
        int dur;
        int stop_k;   // -1 none, 0 during accept cycle, k>0 during cycle k
        int busy_n;
        int done_c;
        int toggles;
        int led_n;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {bz, led, busy, done, cmd_ready} in cycle k after acceptance,
    // where end_k is the last busy cycle.
    function automatic logic [4:0] model(input int k, input int hp, input int dur, input int end_k);
        logic e_bz, e_led, e_busy, e_done, e_rdy;
        e_bz = 1'b0; e_led = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
        if (k <= end_k) begin
            e_busy = 1'b1;
            e_rdy  = 1'b0;
            if (k <= dur * TICK_CYC && hp != 0) begin
                e_led = 1'b1;
                e_bz  = (((k - 1) / hp) % 2) == 1;
            end
        end else if (k == end_k + 1) begin
            e_done = 1'b1;
        end
        return {e_bz, e_led, e_busy, e_done, e_rdy};
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int   busy_n, done_c, tog, led_n;
        logic prev;
        cmd_if.cmd_valid       = 1'b1;
        cmd_if.cmd_half_period = DIV_W'(v.hp);
        cmd_if.cmd_duration    = DUR_W'(v.dur);
        stop = (v.stop_k == 0);
        step();
        cmd_if.cmd_valid       = 1'b0;
        cmd_if.cmd_half_period = DIV_W'($urandom);
        cmd_if.cmd_duration    = DUR_W'($urandom);
        stop   = 1'b0;
        busy_n = 0; done_c = 0; tog = 0; led_n = 0; prev = 1'b0;
        for (int c = 1; c <= BUDGET && done_c == 0; c++) begin
            if (bz !== prev) tog++;
            prev = bz;
            if (busy) busy_n++;
            if (led)  led_n++;
            stop = 1'b0;
            if (done) begin
                done_c = c;
                check($sformatf("vec%0d ready_at_done", idx), 32'(cmd_if.cmd_ready), 32'd1);
            end else begin
                if (c == v.stop_k) stop = 1'b1;
                step();
            end
        end
        stop = 1'b0;
        check($sformatf("vec%0d done_cycle", idx), done_c, v.done_c);
        check($sformatf("vec%0d busy_cycles", idx), busy_n, v.busy_n);
        check($sformatf("vec%0d bz_toggles", idx), tog, v.toggles);
        check($sformatf("vec%0d led_cycles", idx), led_n, v.led_n);
        step();
        check($sformatf("vec%0d done_width", idx), 32'(done), 32'd0);
    endtask

    // Steps until done is seen (bounded); returns the cycle offset or 0.
    task automatic wait_done(output int done_c, output int busy_n, output int first_rise);
        done_c = 0; busy_n = 0; first_rise = 0;
        for (int c = 1; c <= BUDGET && done_c == 0; c++) begin
            if (busy) busy_n++;
            if (bz && first_rise == 0) first_rise = c;
            if (done) done_c = c;
            else step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d_c, b_n, f_r;

        vecs[0] = '{5,   3,  -1,  50,  51, 6,  30};
        vecs[1] = '{0,   2,  -1,  40,  41, 0,   0};
        vecs[2] = '{3,   0,  -1,  20,  21, 0,   0};
        vecs[3] = '{3,   5,  12,  12,  13, 4,  12};
        vecs[4] = '{1,   1,  -1,  30,  31, 10, 10};
        vecs[5] = '{2,   1,  -1,  30,  31, 4,  10};
        vecs[6] = '{7,   2,   1,   1,   2, 0,   1};
        vecs[7] = '{255, 15, -1, 170, 171, 0, 150};
        vecs[8] = '{3,   1,   0,  30,  31, 4,  10};

        rst = 1'b1;
        stop = 1'b0;
        stop_ng = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_half_period = '0;
        cmd_if.cmd_duration = '0;
        cmd_ng_if.cmd_valid = 1'b0;
        cmd_ng_if.cmd_half_period = '0;
        cmd_ng_if.cmd_duration = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step();

        check("reset bz",    32'(bz),   32'd0);
        check("reset led",   32'(led),  32'd0);
        check("reset busy",  32'(busy), 32'd0);
        check("reset done",  32'(done), 32'd0);
        check("reset ready", 32'(cmd_if.cmd_ready), 32'd1);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Abort, then a new command accepted in the done cycle.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_half_period = 8'd3;
        cmd_if.cmd_duration = 4'd5;
        step();
        cmd_if.cmd_valid = 1'b0;
        for (int c = 1; c < 12; c++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("abort done",  32'(done), 32'd1);
        check("abort bz",    32'(bz),   32'd0);
        check("abort busy",  32'(busy), 32'd0);
        check("abort ready", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_half_period = 8'd2;
        cmd_if.cmd_duration = 4'd1;
        step();
        cmd_if.cmd_valid = 1'b0;
        check("abort next accepted", 32'(busy), 32'd1);
        check("abort single done",   32'(done), 32'd0);
        wait_done(d_c, b_n, f_r);
        check("abort next done_cycle", d_c, 31);
        step();

        // Back-to-back with cmd_valid held high.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_half_period = 8'd2;
        cmd_if.cmd_duration = 4'd1;
        step();
        cmd_if.cmd_half_period = 8'd4;
        cmd_if.cmd_duration = 4'd1;
        wait_done(d_c, b_n, f_r);
        check("b2b first done_cycle", d_c, 31);
        check("b2b first rise",       f_r, 3);
        check("b2b ready_at_done",    32'(cmd_if.cmd_ready), 32'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_half_period = 8'd7;
        cmd_if.cmd_duration = 4'd9;
        check("b2b second accepted", 32'(busy), 32'd1);
        check("b2b second led",      32'(led),  32'd1);
        wait_done(d_c, b_n, f_r);
        check("b2b second done_cycle", d_c, 31);
        check("b2b second busy",       b_n, 30);
        check("b2b second first_rise", f_r, 5);
        step();

        // Asynchronous reset in the middle of a note.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_half_period = 8'd1;
        cmd_if.cmd_duration = 4'd3;
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
        check("areset bz high before", 32'(bz), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("areset bz",   32'(bz),   32'd0);
        check("areset busy", 32'(busy), 32'd0);
        check("areset led",  32'(led),  32'd0);
        check("areset done", 32'(done), 32'd0);
        step();
        check("areset held done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("areset ready after", 32'(cmd_if.cmd_ready), 32'd1);
        check("areset no done",     32'(done), 32'd0);

        // Instance built without an articulation gap.
        cmd_ng_if.cmd_valid = 1'b1;
        cmd_ng_if.cmd_half_period = 8'd3;
        cmd_ng_if.cmd_duration = 4'd0;
        step();
        cmd_ng_if.cmd_valid = 1'b0;
        check("nogap zero-dur done",  32'(done_ng), 32'd1);
        check("nogap zero-dur busy",  32'(busy_ng), 32'd0);
        check("nogap zero-dur ready", 32'(cmd_ng_if.cmd_ready), 32'd1);
        step();
        check("nogap done width", 32'(done_ng), 32'd0);
        cmd_ng_if.cmd_valid = 1'b1;
        cmd_ng_if.cmd_duration = 4'd1;
        step();
        cmd_ng_if.cmd_valid = 1'b0;
        d_c = 0; b_n = 0;
        for (int c = 1; c <= BUDGET && d_c == 0; c++) begin
            if (busy_ng) b_n++;
            if (done_ng) d_c = c;
            else step();
        end
        check("nogap note done_cycle", d_c, 11);
        check("nogap note busy",       b_n, 10);
        step();

        // Randomized notes against the reference model.
        for (int n = 0; n < 40; n++) begin
            int hp, dur, natural, stop_k, end_k;
            bit stop_acc;
            hp       = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 6));
            dur      = $urandom_range(0, 3);
            natural  = (dur + GAP_TICKS) * TICK_CYC;
            stop_k   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, natural)) : -1;
            stop_acc = ($urandom_range(0, 4) == 0);
            end_k    = (stop_k > 0) ? stop_k : natural;
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_half_period = DIV_W'(hp);
            cmd_if.cmd_duration = DUR_W'(dur);
            stop = stop_acc;
            step();
            cmd_if.cmd_valid = 1'b0;
            cmd_if.cmd_half_period = DIV_W'($urandom);
            cmd_if.cmd_duration = DUR_W'($urandom);
            stop = 1'b0;
            for (int k = 1; k <= end_k + 1; k++) begin
                check($sformatf("rand n%0d hp%0d dur%0d k%0d {bz,led,busy,done,rdy}", n, hp, dur, k),
                      32'({bz, led, busy, done, cmd_if.cmd_ready}),
                      32'(model(k, hp, dur, end_k)));
                stop = (k == stop_k);
                step();
            end
            stop = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tone_player
